// File: rtl/sprite_word_fifo.sv
// Change-detecting, range-checked sprite word FIFO with a valid/ready output.
// Each distinct in-range word is queued once; a word blocked by a full FIFO stays pending.
module sprite_word_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2,
    parameter logic [9:0]  MAX_X  = 10'd620,
    parameter logic [9:0]  MAX_Y  = 10'd460
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       data_in,
    input  logic              enable,
    input  logic              clear_err,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    output logic              range_err
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [31:0]       mem_q [0:DEPTH-1];
    logic [31:0]       mem_d [0:DEPTH-1];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       last_word_q, last_word_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              overflow_q, overflow_d;
    logic              range_err_q, range_err_d;

    logic        pop;
    logic        push;
    logic        candidate;
    logic        in_range;
    logic        ovf_set;
    logic        rng_set;
    logic [31:0] head;

    always_comb begin
        pop       = out_valid_q & out_ready & (count_q != '0);
        candidate = enable & (data_in != last_word_q);
        in_range  = (data_in[28:19] <= MAX_X) && (data_in[18:9] <= MAX_Y);
        push      = candidate & in_range & ((count_q != FULL_CNT) | pop);
        ovf_set   = candidate & in_range & ~push;
        rng_set   = candidate & ~in_range;

        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        last_word_d = last_word_q;

        if (push) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
            last_word_d     = data_in;
        end
        // A rejected out-of-range word is remembered so it only flags once.
        if (rng_set) begin
            last_word_d = data_in;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        // The registered head must see a word being written this cycle when it lands at the head slot.
        if (push && (rd_ptr_d == wr_ptr_q)) begin
            head = data_in;
        end else begin
            head = mem_q[rd_ptr_d];
        end

        out_valid_d = (count_d != '0);
        out_data_d  = out_valid_d ? head : '0;

        overflow_d  = (overflow_q  & ~clear_err) | ovf_set;
        range_err_d = (range_err_q & ~clear_err) | rng_set;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_word_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            last_word_q <= last_word_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            range_err_q <= range_err_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign range_err  = range_err_q;

endmodule

// File: tb/tb_sprite_word_fifo.sv
// Bench for sprite_word_fifo: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_sprite_word_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXX  = 620;
    localparam int unsigned MAXY  = 460;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_in_i;
    logic        enable_i;
    logic        clear_err_i;
    logic        out_ready_i;
    logic [31:0] out_data;
    logic        out_valid;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        range_err;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] m_last;
    logic        m_ovf;
    logic        m_rerr;

    sprite_word_fifo #(.DEPTH(4), .ADDR_W(2), .MAX_X(10'd620), .MAX_Y(10'd460)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .data_in    (data_in_i),
        .enable     (enable_i),
        .clear_err  (clear_err_i),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready_i),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .range_err  (range_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [31:0] din;
        logic        rdy;
        logic        clr;
        logic        exp_valid;
        logic [31:0] exp_data;
        int          exp_count;
        logic        exp_ovf;
        logic        exp_rerr;
    } vec_t;

    vec_t vt[10];

    function automatic logic [31:0] mk(int unsigned s, int unsigned x, int unsigned y, int unsigned o);
        logic [31:0] w;
        w = {s[2:0], x[9:0], y[9:0], o[8:0]};
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_last = '0;
        m_ovf  = 1'b0;
        m_rerr = 1'b0;
    endfunction

    // Rules applied per clock edge using the inputs present at that edge.
    function automatic void model_step();
        bit pop, push, cand, bad, oset;
        int unsigned x, y;
        pop  = out_ready_i && (mq.size() > 0);
        cand = enable_i && (data_in_i != m_last);
        x    = data_in_i[28:19];
        y    = data_in_i[18:9];
        bad  = cand && (x > MAXX || y > MAXY);
        push = cand && !bad && (mq.size() < DEPTH || pop);
        oset = cand && !bad && !push;
        if (bad || push) m_last = data_in_i;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(data_in_i);
        m_ovf  = (m_ovf  && !clear_err_i) || oset;
        m_rerr = (m_rerr && !clear_err_i) || bad;
    endfunction

    task automatic check_model(input string tag);
        logic exp_v;
        exp_v = (mq.size() != 0);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, exp_v});
        chk({tag, ".count"}, {29'd0, fifo_count}, 32'(mq.size()));
        chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, m_ovf});
        chk({tag, ".rerr"}, {31'd0, range_err}, {31'd0, m_rerr});
        if (exp_v) chk({tag, ".data"}, out_data, mq[0]);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic drive(input logic en, input logic [31:0] d, input logic rdy, input logic clr);
        enable_i    = en;
        data_in_i   = d;
        out_ready_i = rdy;
        clear_err_i = clr;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [31:0] w[1:10];
    logic [31:0] got[$];
    logic [31:0] pool[6];
    int          vcnt;

    initial begin
        vt[0] = '{1'b1, 32'h2000_0000, 1'b1, 1'b0, 1'b1, 32'h2000_0000, 1, 1'b0, 1'b0};
        vt[1] = '{1'b1, 32'h2000_0000, 1'b1, 1'b0, 1'b0, 32'h0,         0, 1'b0, 1'b0};
        vt[2] = '{1'b1, 32'h2000_0000, 1'b1, 1'b0, 1'b0, 32'h0,         0, 1'b0, 1'b0};
        vt[3] = '{1'b1, 32'h2028_0000, 1'b0, 1'b0, 1'b1, 32'h2028_0000, 1, 1'b0, 1'b0};
        vt[4] = '{1'b1, 32'h3368_0000, 1'b0, 1'b0, 1'b1, 32'h2028_0000, 1, 1'b0, 1'b1};
        vt[5] = '{1'b1, 32'h3368_0000, 1'b0, 1'b1, 1'b1, 32'h2028_0000, 1, 1'b0, 1'b0};
        vt[6] = '{1'b1, 32'h3360_0000, 1'b1, 1'b0, 1'b1, 32'h3360_0000, 1, 1'b0, 1'b0};
        vt[7] = '{1'b0, 32'h3360_0000, 1'b1, 1'b0, 1'b0, 32'h0,         0, 1'b0, 1'b0};
        vt[8] = '{1'b1, 32'h2003_9A00, 1'b0, 1'b0, 1'b0, 32'h0,         0, 1'b0, 1'b1};
        vt[9] = '{1'b0, 32'h2003_9A00, 1'b0, 1'b1, 1'b0, 32'h0,         0, 1'b0, 1'b0};
        for (int i = 1; i <= 10; i++) w[i] = mk(2, 9 + 1 * ((i <= 5) ? i : i + 5), 1, 0);

        drive(1'b0, '0, 1'b0, 1'b0);
        do_reset();
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.count", {29'd0, fifo_count}, 32'd0);
        chk("rst.data", out_data, 32'd0);
        chk("rst.ovf", {31'd0, overflow}, 32'd0);
        chk("rst.rerr", {31'd0, range_err}, 32'd0);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].en, vt[i].din, vt[i].rdy, vt[i].clr);
            step($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.valid", i), {31'd0, out_valid}, {31'd0, vt[i].exp_valid});
            chk($sformatf("tbl%0d.count", i), {29'd0, fifo_count}, 32'(vt[i].exp_count));
            chk($sformatf("tbl%0d.ovf", i), {31'd0, overflow}, {31'd0, vt[i].exp_ovf});
            chk($sformatf("tbl%0d.rerr", i), {31'd0, range_err}, {31'd0, vt[i].exp_rerr});
            if (vt[i].exp_valid) chk($sformatf("tbl%0d.data", i), out_data, vt[i].exp_data);
        end

        // Overflow: five distinct words into a stalled FIFO, then drain in order
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, w[i], 1'b0, 1'b0);
            step("ovf_fill");
        end
        chk("ovf.count", {29'd0, fifo_count}, 32'd4);
        chk("ovf.flag", {31'd0, overflow}, 32'd1);
        out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) got.push_back(out_data);
            step("ovf_drain");
        end
        chk("ovf.drained", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++)
            chk($sformatf("ovf.order%0d", i), got[i], w[i + 1]);
        drive(1'b0, w[5], 1'b1, 1'b1);
        step("ovf_clear");
        chk("ovf.cleared", {31'd0, overflow}, 32'd0);

        // Full FIFO with simultaneous pop and push
        for (int i = 6; i <= 9; i++) begin
            drive(1'b1, w[i], 1'b0, 1'b0);
            step("pp_fill");
        end
        chk("pp.full", {29'd0, fifo_count}, 32'd4);
        drive(1'b1, w[10], 1'b1, 1'b0);
        step("pp_swap");
        chk("pp.count", {29'd0, fifo_count}, 32'd4);
        chk("pp.ovf", {31'd0, overflow}, 32'd0);
        chk("pp.head", out_data, w[7]);
        enable_i = 1'b0;
        repeat (5) step("pp_drain");

        // Asynchronous reset with three words queued
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, mk(3, 100 + i, 50, 7), 1'b0, 1'b0);
            step("ar_fill");
        end
        chk("ar.pre", {29'd0, fifo_count}, 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar.valid", {31'd0, out_valid}, 32'd0);
        chk("ar.count", {29'd0, fifo_count}, 32'd0);
        model_reset();
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) step("ar_after");

        // Constant input: one transfer; then x change gives one more
        drive(1'b1, 32'h2000_0000, 1'b1, 1'b0);
        vcnt = 0;
        for (int i = 0; i < 100; i++) begin
            step("hold");
            if (out_valid) vcnt++;
        end
        chk("hold.transfers", 32'(vcnt), 32'd1);
        chk("hold.count", {29'd0, fifo_count}, 32'd0);
        data_in_i = 32'h2028_0000;
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            step("xchg");
            if (out_valid) begin
                vcnt++;
                chk("xchg.x", {22'd0, out_data[28:19]}, 32'd5);
            end
        end
        chk("xchg.transfers", 32'(vcnt), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 6; i++) pool[i] = mk($urandom_range(0, 7), $urandom_range(0, 700), $urandom_range(0, 520), $urandom_range(0, 511));
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0)
                pool[$urandom_range(0, 5)] = mk($urandom_range(0, 7), $urandom_range(0, 700), $urandom_range(0, 520), $urandom_range(0, 511));
            drive($urandom_range(0, 3) != 0, pool[$urandom_range(0, 5)],
                  $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
